// File: rtl/mux8_scan_pkg.sv
// mux8_scan_pkg: shared types and sizes for the 8:1 mux scan controller.
//   state_e  : FSM state (IDLE waits for a word, SCAN steps the select)
//   SEL_W    : mux select width
//   NUM_IN   : number of mux data inputs
//   DWELL_W  : dwell counter width
package mux8_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam int SEL_W   = 3;
  localparam int NUM_IN  = 8;
  localparam int DWELL_W = 8;

endpackage

// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: upstream sequencer for an 8:1 mux (parallel-to-serial).
// Accepts one 8-bit word over valid/ready, holds it on the mux data inputs
// a..h and walks sel 0..7, holding each select for DWELL cycles. bit_strobe
// marks the cycle in which the mux output is valid for the current sel.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_valid  : word to scan (bit 7 -> a ... bit 0 -> h)
//   in_ready          : high in IDLE; a word is taken on valid && ready
//   hold              : freezes select and dwell count during a scan
//   a..h              : latched word bits to the mux
//   sel               : mux select
//   bit_strobe        : sample mux y this cycle
//   busy              : scan in progress
//   done              : pulse on the final strobe of a word
module mux8_scan_ctrl
  import mux8_scan_pkg::*;
#(
  parameter int DWELL = 1   // 1..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g,
  output logic             h,
  output logic [SEL_W-1:0] sel,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_IN - 1);

  state_e               state;
  logic [DWELL_W-1:0]   cnt;
  logic [NUM_IN-1:0]    word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
      word  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // hold is ignored here; acceptance depends only on in_valid
          if (in_valid) begin
            word  <= in_data;
            sel   <= '0;
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!hold) begin
            if (cnt == DWELL_LAST) begin
              cnt <= '0;
              // last strobe of the word: back to IDLE with sel parked at 0
              if (sel == SEL_LAST) begin
                sel   <= '0;
                state <= IDLE;
              end else begin
                sel <= sel + SEL_W'(1);
              end
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state == SCAN);
  // hold reaches the strobe combinationally so a held cycle never strobes
  assign bit_strobe = (state == SCAN) && (cnt == DWELL_LAST) && !hold;
  assign done       = bit_strobe && (sel == SEL_LAST);

  assign {a, b, c, d, e, f, g, h} = word;

endmodule
